// File: rtl/fp16_round_arbiter.sv
// Round-robin share of one normalize-and-round stage between two requesters.
// Two-deep elastic pipeline: S1 captures the granted request, S2 holds the rounded result.
module fp16_round_arbiter #(
    parameter int MAN_W = 16,
    parameter int EXP_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             r0_valid,
    output logic             r0_ready,
    input  logic [MAN_W-1:0] r0_man,
    input  logic [EXP_W-1:0] r0_exp,
    input  logic             r1_valid,
    output logic             r1_ready,
    input  logic [MAN_W-1:0] r1_man,
    input  logic [EXP_W-1:0] r1_exp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [MAN_W-1:0] out_man,
    output logic [EXP_W-1:0] out_exp,
    output logic [1:0]       out_exc,
    output logic             out_src
);

    localparam logic [EXP_W-1:0] EXP_MAX = '1;

    logic [1:0]            reqValid;
    logic [1:0][MAN_W-1:0] reqMan;
    logic [1:0][EXP_W-1:0] reqExp;

    assign reqValid = {r1_valid, r0_valid};
    assign reqMan   = {r1_man, r0_man};
    assign reqExp   = {r1_exp, r0_exp};

    // vldPipe[1] = S1 occupied, vldPipe[2] = S2 occupied (out_valid)
    logic [2:1]       vldPipe;
    logic             last;
    logic             grant;
    logic             s1Load;
    logic             s2Load;
    logic             accept;
    logic [MAN_W-1:0] s1Man;
    logic [EXP_W-1:0] s1Exp;
    logic             s1Src;

    assign s2Load = !vldPipe[2] || out_ready;
    assign s1Load = !vldPipe[1] || s2Load;
    assign grant  = (&reqValid) ? !last : reqValid[1];
    // Gated by rst so both readys fall the moment reset is asserted.
    assign accept = s1Load && (|reqValid) && !rst;

    assign r0_ready  = accept && !grant;
    assign r1_ready  = accept && grant;
    assign out_valid = vldPipe[2];

    logic [MAN_W:0]   sum;
    logic [MAN_W-1:0] rndMan;
    logic [EXP_W-1:0] rndExp;
    logic [1:0]       rndExc;

    always_comb begin
        sum    = {1'b0, s1Man} + (MAN_W+1)'(4);
        rndMan = s1Man;
        rndExp = s1Exp;
        rndExc = 2'b00;
        if (s1Exp == EXP_MAX) begin
            rndExc = 2'b10;
        end else if (s1Man[1]) begin
            if (sum[MAN_W]) begin
                rndMan = sum[MAN_W:1];
                rndExp = s1Exp + EXP_W'(1);
            end else begin
                rndMan = sum[MAN_W-1:0];
            end
            // Only reachable through the carry increment.
            if (rndExp == EXP_MAX) begin
                rndMan = '0;
                rndExc = 2'b01;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vldPipe <= '0;
            last    <= 1'b1;
            s1Man   <= '0;
            s1Exp   <= '0;
            s1Src   <= 1'b0;
            out_man <= '0;
            out_exp <= '0;
            out_exc <= 2'b00;
            out_src <= 1'b0;
        end else begin
            if (s1Load) begin
                vldPipe[1] <= accept;
                if (accept) begin
                    s1Man <= reqMan[grant];
                    s1Exp <= reqExp[grant];
                    s1Src <= grant;
                    last  <= grant;
                end
            end
            if (s2Load) begin
                vldPipe[2] <= vldPipe[1];
                if (vldPipe[1]) begin
                    out_man <= rndMan;
                    out_exp <= rndExp;
                    out_exc <= rndExc;
                    out_src <= s1Src;
                end
            end
        end
    end

endmodule

// File: tb/tb_fp16_round_arbiter.sv
// Randomized bench for fp16_round_arbiter: requesters hold requests until accepted and a
// depth-2 elastic-pipeline model predicts readys, out_valid timing and rounded results.
module tb_fp16_round_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        r0_valid, r0_ready, r1_valid, r1_ready;
    logic [15:0] r0_man, r1_man;
    logic [5:0]  r0_exp, r1_exp;
    logic        out_valid, out_ready;
    logic [15:0] out_man;
    logic [5:0]  out_exp;
    logic [1:0]  out_exc;
    logic        out_src;

    fp16_round_arbiter #(.MAN_W(16), .EXP_W(6)) dut (
        .clk(clk), .rst(rst),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_man(r0_man), .r0_exp(r0_exp),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_man(r1_man), .r1_exp(r1_exp),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_man(out_man), .out_exp(out_exp), .out_exc(out_exc), .out_src(out_src)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] man;
        logic [5:0]  exp;
        logic [1:0]  exc;
        logic        src;
        int          acceptEdge;
    } expT;

    int          nVec = 0;
    int          nBad = 0;
    int          edgeCnt = 0;
    int          accCnt;
    int          prob[2];
    int          outPct;
    logic        lastModel;
    logic        pend[2];
    logic        hasK[2];
    logic [15:0] pMan[2];
    logic [5:0]  pExp[2];
    expT         kRes[2];
    logic        prevWait[2];
    logic [22:0] prevReq[2];
    expT         q[$];
    int          accLog[$];

    always @(posedge clk) edgeCnt <= edgeCnt + 1;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] expv);
        nVec++;
        if (got !== expv) begin
            nBad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, expv, $time);
        end
    endtask

    // Rounding rules written as plain integer arithmetic.
    function automatic expT refRound(logic [15:0] m, logic [5:0] e, logic s);
        expT r;
        int  sum;
        int  ne;
        r.man = m; r.exp = e; r.exc = 2'd0; r.src = s; r.acceptEdge = 0;
        if (e == 6'd63) begin
            r.exc = 2'd2;
        end else if ((m % 4) >= 2) begin
            sum = int'(m) + 4;
            ne  = int'(e);
            if (sum >= 65536) begin
                sum = sum / 2;
                ne++;
            end
            if (ne == 63) begin
                r.man = 16'h0; r.exp = 6'd63; r.exc = 2'd1;
            end else begin
                r.man = 16'(sum); r.exp = 6'(ne);
            end
        end
        return r;
    endfunction

    task automatic genReq(input int i);
        int pick;
        pick    = int'($urandom_range(0, 3));
        hasK[i] = 1'b0;
        pend[i] = 1'b1;
        case (pick)
            0: begin pMan[i] = 16'($urandom); pExp[i] = 6'($urandom_range(0, 63)); end
            1: begin pMan[i] = 16'hFFFC | 16'($urandom_range(0, 3)); pExp[i] = 6'($urandom_range(55, 63)); end
            2: begin pMan[i] = 16'($urandom) | 16'h0002; pExp[i] = 6'($urandom_range(0, 62)); end
            default: begin pMan[i] = 16'($urandom); pExp[i] = 6'd62; end
        endcase
    endtask

    task automatic drive();
        for (int i = 0; i < 2; i++)
            if (!pend[i] && $urandom_range(0, 99) < prob[i]) genReq(i);
        r0_valid  = pend[0]; r0_man = pMan[0]; r0_exp = pExp[0];
        r1_valid  = pend[1]; r1_man = pMan[1]; r1_exp = pExp[1];
        out_ready = ($urandom_range(0, 99) < outPct);
    endtask

    // Called at negedge after inputs are driven: check, then update the model.
    task automatic cycle();
        logic       expOv, anyV, both, win, canAcc;
        logic [1:0] acc;
        expT        e;
        #1;
        if (prevWait[0]) checkVal("hold0", {r0_valid, r0_man, r0_exp}, prevReq[0]);
        if (prevWait[1]) checkVal("hold1", {r1_valid, r1_man, r1_exp}, prevReq[1]);
        expOv = (q.size() > 0) && (q[0].acceptEdge < edgeCnt);
        checkVal("out_valid", out_valid, expOv);
        if (expOv) begin
            checkVal("out_man", out_man, q[0].man);
            checkVal("out_exp", out_exp, q[0].exp);
            checkVal("out_exc", out_exc, q[0].exc);
            checkVal("out_src", out_src, q[0].src);
        end
        anyV   = r0_valid || r1_valid;
        both   = r0_valid && r1_valid;
        win    = both ? !lastModel : r1_valid;
        canAcc = (q.size() < 2) || out_ready;
        checkVal("r0_ready", r0_ready, anyV && canAcc && !win);
        checkVal("r1_ready", r1_ready, anyV && canAcc && win);
        if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
        acc = {r1_valid && r1_ready, r0_valid && r0_ready};
        for (int i = 0; i < 2; i++) begin
            if (acc[i]) begin
                e = hasK[i] ? kRes[i] : refRound(pMan[i], pExp[i], 1'(i));
                e.src = 1'(i);
                e.acceptEdge = edgeCnt + 1;
                q.push_back(e);
                accLog.push_back(i);
                lastModel = 1'(i);
                pend[i] = 1'b0;
                accCnt++;
            end
        end
        prevWait[0] = r0_valid && !r0_ready; prevReq[0] = {r0_valid, r0_man, r0_exp};
        prevWait[1] = r1_valid && !r1_ready; prevReq[1] = {r1_valid, r1_man, r1_exp};
    endtask

    task automatic runCycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            drive();
            cycle();
        end
    endtask

    task automatic directed(input int i, input logic [15:0] m, input logic [5:0] e,
                            input logic [15:0] km, input logic [5:0] ke, input logic [1:0] kx);
        int n;
        prob = '{0, 0};
        outPct = 100;
        @(negedge clk);
        pend[i] = 1'b1; pMan[i] = m; pExp[i] = e; hasK[i] = 1'b1;
        kRes[i].man = km; kRes[i].exp = ke; kRes[i].exc = kx;
        kRes[i].src = 1'(i); kRes[i].acceptEdge = 0;
        drive();
        cycle();
        n = 0;
        while (pend[i] && n < 20) begin
            runCycles(1);
            n++;
        end
        checkVal("dirAccepted", pend[i], 1'b0);
        runCycles(4);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        r0_valid = 0; r1_valid = 0; r0_man = 0; r1_man = 0; r0_exp = 0; r1_exp = 0;
        out_ready = 0;
        prob = '{0, 0}; outPct = 100; accCnt = 0;
        lastModel = 1'b1;
        pend = '{0, 0}; hasK = '{0, 0}; prevWait = '{0, 0};
        pMan = '{0, 0}; pExp = '{0, 0};
        repeat (2) @(posedge clk);
        @(negedge clk);
        r0_valid = 1; r1_valid = 1; out_ready = 1;
        #1;
        checkVal("rst_out_valid", out_valid, 1'b0);
        checkVal("rst_r0_ready", r0_ready, 1'b0);
        checkVal("rst_r1_ready", r1_ready, 1'b0);
        checkVal("rst_out_man", out_man, 16'h0);
        checkVal("rst_out_exp", out_exp, 6'h0);
        checkVal("rst_out_exc", out_exc, 2'b00);
        checkVal("rst_out_src", out_src, 1'b0);
        r0_valid = 0; r1_valid = 0;
        rst = 1'b0;

        // Tie arbitration straight out of reset: r0 first, then alternate.
        prob = '{100, 100}; outPct = 100;
        accLog.delete();
        runCycles(6);
        checkVal("arbCount", accLog.size(), 6);
        for (int i = 0; i < 6 && i < accLog.size(); i++) checkVal("arbSeq", accLog[i], i % 2);
        prob = '{0, 0};
        runCycles(6);

        // Lone requester granted every cycle.
        prob = '{0, 100}; accCnt = 0;
        runCycles(6);
        checkVal("singleCnt", accCnt, 6);
        prob = '{0, 0};
        runCycles(4);

        directed(0, 16'h8002, 6'd5,  16'h8006, 6'd5,  2'b00);
        directed(1, 16'hFFFE, 6'd10, 16'h8001, 6'd11, 2'b00);
        directed(0, 16'h1234, 6'd3,  16'h1234, 6'd3,  2'b00);
        directed(1, 16'hFFFE, 6'd62, 16'h0000, 6'd63, 2'b01);
        directed(0, 16'h0F0F, 6'd63, 16'h0F0F, 6'd63, 2'b10);

        // Backpressure from an empty pipe: exactly two accepted, then drain.
        prob = '{100, 100}; outPct = 0; accCnt = 0;
        runCycles(5);
        checkVal("bpAccepts", accCnt, 2);
        outPct = 100;
        runCycles(6);
        prob = '{0, 0};
        runCycles(6);
        checkVal("bpDrained", q.size(), 0);

        prob = '{60, 60}; outPct = 70;
        runCycles(300);

        // Asynchronous reset between edges while streaming.
        prob = '{100, 100}; outPct = 70;
        runCycles(5);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checkVal("arst_out_valid", out_valid, 1'b0);
        checkVal("arst_r0_ready", r0_ready, 1'b0);
        checkVal("arst_r1_ready", r1_ready, 1'b0);
        q.delete();
        lastModel = 1'b1;
        prevWait = '{0, 0};
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        pend = '{1, 1};
        accLog.delete();
        drive();
        cycle();
        checkVal("tieAfterRst", (accLog.size() > 0) ? accLog[0] : 9, 0);
        runCycles(20);
        prob = '{0, 0}; outPct = 100;
        runCycles(8);
        checkVal("endEmpty", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
        $finish;
    end

endmodule

// File: doc/fp16_round_arbiter.md
# fp16_round_arbiter

Shares one normalize-and-round stage between two 16-bit floating-point requesters (adder path r0, subtract/secondary path r1). Requests carry an unrounded 16-bit mantissa and a 6-bit exponent. The block arbitrates round-robin, pipelines the rounding step, and returns rounded results with a source tag under valid/ready backpressure. It sits between the mantissa-alignment/add stages and the result packer.

## Interface
- MAN_W, 16, mantissa width (block verified at 16 only)
- EXP_W, 6, exponent width (block verified at 6 only)

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- r0_valid  in  1  requester 0 has a request
- r0_ready  out  1  requester 0 request accepted this cycle (valid&&ready)
- r0_man  in  16  requester 0 unrounded mantissa
- r0_exp  in  6  requester 0 exponent
- r1_valid / r1_ready / r1_man / r1_exp: same as r0, for requester 1
- out_valid  out  1  rounded result available
- out_ready  in  1  consumer accepts result
- out_man  out  16  rounded mantissa
- out_exp  out  6  adjusted exponent
- out_exc  out  2  00 normal, 01 overflow, 10 special input (exp all ones)
- out_src  out  1  requester index of this result

## Operation
- Two register stages: S1 capture (man, exp, src, v1) and S2 output (out_*).
- Advance: S2 loads when !out_valid || out_ready. S1 loads when !v1 || S2 loads.
- Arbiter: a last pointer holds the index of the last requester granted. The grant goes to the single valid requester. If both are valid, it goes to !last. last updates only on an accepted transfer.
- rX_ready = S1-load && grant==X. At most one ready is high per cycle. Ready never depends on out_ready combinationally beyond the S1-load term.
- Round function, computed S1→S2:
  - If exp==6'h3F: pass-through man/exp, exc=10.
  - Else if man[1]==0: pass-through, exc=00.
  - Else t = {1'b0,man}+17'd4. If t[16]: man'=t[16:1], exp'=exp+1. Otherwise man'=t[15:0], exp'=exp.
  - If exp' == 6'h3F after the increment: exc=01, man'=16'h0000, exp'=6'h3F. Otherwise exc=00.
- out_src carries the S1 src unchanged.
- Reset state:
  - All valid and ready outputs are 0. out_man, out_exp, out_exc and out_src are 0.
  - v1=0. last=1, so r0 wins the first tie.
- Reset asserted mid-operation discards in-flight S1/S2 contents. No result is emitted for them.

## Timing
- Latency: a request accepted at edge N yields out_valid=1 after edge N+1 (two edges: S1 at N, S2 at N+1).
- Throughput: 1 result/cycle while out_ready=1. Requesters alternate when both are continuously valid.
- Backpressure: with out_ready=0 and out_valid=1, out_* stay stable. S1 holds if full. Both readys go low once S1 is full. No data loss or duplication.
- Release: when out_ready returns high, S2 takes S1 on that edge and the arbiter may accept on the same edge. There are no bubbles.
- Simultaneous valid: exactly one is accepted per cycle, and the loser keeps its valid/data stable until accepted. This is a requester obligation; the bench must check it.
- Starvation bound: with both valid, a requester waits at most one accepted transfer.

## Test plan
- Rounding without carry: r0 man=16'h8002 exp=6'd5 -> out_man=16'h8006, out_exp=5, out_exc=00, out_src=0, two edges after accept.
- Rounding with carry: r1 man=16'hFFFE exp=6'd10 -> out_man=16'h8001, out_exp=11, exc=00, src=1. Pass-through: man=16'h1234 exp=3 -> out 16'h1234, 3, exc=00.
- Overflow and special:
  - man=16'hFFFE exp=6'd62 -> out_man=0, out_exp=63, exc=01.
  - exp=6'd63 man=16'h0F0F -> unchanged, exc=10.
- Arbitration: r0 and r1 both valid for 6 cycles with out_ready=1 -> out_src sequence 0,1,0,1,0,1 with no bubbles. A single valid requester is granted every cycle.
- Backpressure: out_ready=0 for 5 cycles with both requesters streaming -> out_* stable, exactly two transfers accepted, both readys low thereafter. On release, results drain in order with none lost.
- Async reset: assert rst mid-stream, between edges -> out_valid, r0_ready and r1_ready drop immediately. After deassert, the first tie is granted to r0 and no stale result appears.
